// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding and the grouped stage-control bundle.
package hazard_pkg;

    // Controller modes: normal flow, load-use bubble run, MUL/DIV holding EX
    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_STALL  = 2'd1,
        MULDIV_BUSY = 2'd2
    } hz_state_e;

    // Eight stage-control outputs, MSB first in this order
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
    } hz_ctrl_t;

    // Free-flowing pipeline: every register advances, nothing squashed
    localparam hz_ctrl_t HZ_CTRL_DEFAULT = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
        exmem_write: 1'b1, memwb_write: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0
    };

    // Held in reset: nothing advances, every stage is loaded with a NOP
    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
        exmem_write: 1'b0, memwb_write: 1'b0,
        ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b1
    };

    // Data-memory wait: whole pipeline frozen in place, no squashing
    localparam hz_ctrl_t HZ_CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
        exmem_write: 1'b0, memwb_write: 1'b0,
        ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_reg;

    // Clear dominates; otherwise count up and stick at all-ones
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            count_reg <= '0;
        end else if (inc_i && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles,
// multi-cycle MUL/DIV occupancy of EX, data-memory freeze and branch
// flush, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MULDIV_LAT   = 4,
    parameter int CNT_W        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
    input  logic                  ifid_rs1_used_i,
    input  logic                  ifid_rs2_used_i,
    input  logic                  ifid_muldiv_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_stall_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_write_o,
    output logic                  exmem_write_o,
    output logic                  memwb_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_bubble_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam logic [4:0] LOAD_CNT_INIT   = 5'(LOAD_BUBBLES - 1);
    localparam logic [4:0] MULDIV_CNT_INIT = 5'(MULDIV_LAT - 1);

    hz_state_e  state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    hz_ctrl_t   ctrl;
    logic       load_use_hit;
    logic [1:0] perf_inc;
    logic [CNT_W-1:0] perf_val [2];

    // Load in EX whose destination is actually read by the instruction in ID
    always_comb begin
        load_use_hit = idex_memread_i && (idex_rd_i != '0) &&
                       ((ifid_rs1_used_i && (idex_rd_i == ifid_rs1_i)) ||
                        (ifid_rs2_used_i && (idex_rd_i == ifid_rs2_i)));
    end

    // Next state and stage controls; priority reset > mem stall > busy state > hit > branch
    always_comb begin
        ctrl       = HZ_CTRL_DEFAULT;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!rst_i) begin
            ctrl = HZ_CTRL_RESET;
        end else if (mem_stall_i) begin
            // Freeze everything; a busy state's final cycle is thereby extended
            ctrl = HZ_CTRL_FREEZE;
        end else begin
            case (state_reg)
                LOAD_STALL: begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                    cnt_next         = cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1) begin
                        state_next = RUN;
                    end
                end
                MULDIV_BUSY: begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.ifid_write   = 1'b0;
                    ctrl.idex_write   = 1'b0;
                    ctrl.exmem_bubble = 1'b1;
                    cnt_next          = cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    if (load_use_hit) begin
                        // Hold IF/ID, drop a NOP into EX; a same-cycle branch waits
                        ctrl.pc_write    = 1'b0;
                        ctrl.ifid_write  = 1'b0;
                        ctrl.idex_bubble = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_next = LOAD_STALL;
                            cnt_next   = LOAD_CNT_INIT;
                        end
                    end else begin
                        // MUL/DIV enters EX this cycle, then occupies it
                        if (ifid_muldiv_i) begin
                            state_next = MULDIV_BUSY;
                            cnt_next   = MULDIV_CNT_INIT;
                        end
                        if (branch_taken_i) begin
                            ctrl.ifid_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State register; reset abandons any stall in progress
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= RUN;
            cnt_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Index 0 counts PC-held cycles, index 1 counts issued flushes
    assign perf_inc[0] = ~ctrl.pc_write;
    assign perf_inc[1] = ctrl.ifid_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .clr_n_i (rst_i),
                .inc_i   (perf_inc[gi]),
                .count_o (perf_val[gi])
            );
        end
    endgenerate

    assign stall_cycles_o = perf_val[0];
    assign flush_count_o  = perf_val[1];

    assign pc_write_o     = ctrl.pc_write;
    assign ifid_write_o   = ctrl.ifid_write;
    assign idex_write_o   = ctrl.idex_write;
    assign exmem_write_o  = ctrl.exmem_write;
    assign memwb_write_o  = ctrl.memwb_write;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_bubble_o  = ctrl.idex_bubble;
    assign exmem_bubble_o = ctrl.exmem_bubble;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic,
// compared each cycle against a remaining-stall-cycles reference model.
module tb_pipeline_hazard_ctrl;

    localparam int RW  = 5;
    localparam int LB  = 2;
    localparam int ML  = 4;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          idex_memread_i;
    logic [RW-1:0] idex_rd_i, ifid_rs1_i, ifid_rs2_i;
    logic          ifid_rs1_used_i, ifid_rs2_used_i;
    logic          ifid_muldiv_i, branch_taken_i, mem_stall_i;
    logic          pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o;
    logic          ifid_flush_o, idex_bubble_o, exmem_bubble_o;
    logic [CW-1:0] stall_cycles_o, flush_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: which kind of stall is pending and how many cycles remain
    int m_kind = 0;   // 0 none, 1 load, 2 muldiv
    int m_left = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    logic [7:0] obs_ctrl;
    int         obs_sc, obs_fc;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (RW),
        .LOAD_BUBBLES (LB),
        .MULDIV_LAT   (ML),
        .CNT_W        (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .idex_memread_i  (idex_memread_i),
        .idex_rd_i       (idex_rd_i),
        .ifid_rs1_i      (ifid_rs1_i),
        .ifid_rs2_i      (ifid_rs2_i),
        .ifid_rs1_used_i (ifid_rs1_used_i),
        .ifid_rs2_used_i (ifid_rs2_used_i),
        .ifid_muldiv_i   (ifid_muldiv_i),
        .branch_taken_i  (branch_taken_i),
        .mem_stall_i     (mem_stall_i),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .idex_write_o    (idex_write_o),
        .exmem_write_o   (exmem_write_o),
        .memwb_write_o   (memwb_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_bubble_o   (idex_bubble_o),
        .exmem_bubble_o  (exmem_bubble_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_count_o   (flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic set_in(input bit rst, input bit mr, input int rd, input int rs1,
                          input int rs2, input bit u1, input bit u2, input bit md,
                          input bit br, input bit ms);
        rst_i           = rst;
        idex_memread_i  = mr;
        idex_rd_i       = RW'(rd);
        ifid_rs1_i      = RW'(rs1);
        ifid_rs2_i      = RW'(rs2);
        ifid_rs1_used_i = u1;
        ifid_rs2_used_i = u2;
        ifid_muldiv_i   = md;
        branch_taken_i  = br;
        mem_stall_i     = ms;
    endtask

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    // One clock: sample outputs mid-cycle, compare to the model, then advance both
    task automatic step(input string tag);
        logic [7:0] exp_ctrl;
        int n_kind, n_left, n_sc, n_fc;
        bit hit;
        @(negedge clk_i);
        obs_ctrl = {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
                    memwb_write_o, ifid_flush_o, idex_bubble_o, exmem_bubble_o};
        obs_sc = int'(stall_cycles_o);
        obs_fc = int'(flush_count_o);
        n_kind = m_kind; n_left = m_left; n_sc = m_sc; n_fc = m_fc;
        hit = idex_memread_i && (idex_rd_i != 0) &&
              ((ifid_rs1_used_i && idex_rd_i == ifid_rs1_i) ||
               (ifid_rs2_used_i && idex_rd_i == ifid_rs2_i));
        if (!rst_i) begin
            exp_ctrl = 8'b00000111;
            n_kind = 0; n_left = 0; n_sc = 0; n_fc = 0;
        end else if (mem_stall_i) begin
            exp_ctrl = 8'b00000000;
            n_sc = sat_inc(m_sc);
        end else if (m_kind == 1) begin
            exp_ctrl = 8'b00111010;
            n_sc = sat_inc(m_sc);
            n_left = m_left - 1;
            if (n_left == 0) n_kind = 0;
        end else if (m_kind == 2) begin
            exp_ctrl = 8'b00011001;
            n_sc = sat_inc(m_sc);
            n_left = m_left - 1;
            if (n_left == 0) n_kind = 0;
        end else if (hit) begin
            exp_ctrl = 8'b00111010;
            n_sc = sat_inc(m_sc);
            if (LB - 1 > 0) begin n_kind = 1; n_left = LB - 1; end
        end else begin
            exp_ctrl = 8'b11111000;
            if (ifid_muldiv_i) begin n_kind = 2; n_left = ML - 1; end
            if (branch_taken_i) begin
                exp_ctrl[2] = 1'b1;
                n_fc = sat_inc(m_fc);
            end
        end
        check_eq({tag, ".ctrl"}, int'(obs_ctrl), int'(exp_ctrl));
        check_eq({tag, ".stall_cnt"}, obs_sc, m_sc);
        check_eq({tag, ".flush_cnt"}, obs_fc, m_fc);
        $display("cyc %s in{rst=%0b mr=%0b rd=%0d rs=%0d/%0d u=%0b%0b md=%0b br=%0b ms=%0b} ctrl=%b sc=%0d fc=%0d",
                 tag, rst_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
                 ifid_rs1_used_i, ifid_rs2_used_i, ifid_muldiv_i, branch_taken_i,
                 mem_stall_i, obs_ctrl, obs_sc, obs_fc);
        @(posedge clk_i);
        m_kind = n_kind; m_left = n_left; m_sc = n_sc; m_fc = n_fc;
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        // Reset state
        step("rst0");
        check_eq("rst_ctrl", int'(obs_ctrl), 8'h07);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle");
        check_eq("idle_ctrl", int'(obs_ctrl), 8'hF8);
        check_eq("idle_sc", obs_sc, 0);

        // Load x5 in EX, ID reads x5 via rs1: two bubble cycles
        do_reset();
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        step("lu_hit");
        check_eq("lu_hit_pc", int'(obs_ctrl[7]), 0);
        set_in(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
        step("lu_stall");
        check_eq("lu_stall_bub", int'(obs_ctrl[1]), 1);
        step("lu_done");
        check_eq("lu_done_pc", int'(obs_ctrl[7]), 1);
        check_eq("lu_sc", obs_sc, 2);

        // x0 destination and unused rs2 never stall
        set_in(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        step("lu_x0");
        check_eq("lu_x0_pc", int'(obs_ctrl[7]), 1);
        set_in(1, 1, 7, 3, 7, 1, 0, 0, 0, 0);
        step("lu_unused");
        check_eq("lu_unused_pc", int'(obs_ctrl[7]), 1);

        // Hit plus branch: stall wins, branch flushes once back in RUN
        do_reset();
        set_in(1, 1, 9, 9, 0, 1, 0, 0, 1, 0);
        step("hb_hit");
        check_eq("hb_hit_flush", int'(obs_ctrl[2]), 0);
        set_in(1, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        step("hb_stall");
        step("hb_run");
        check_eq("hb_run_flush", int'(obs_ctrl[2]), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("hb_after");
        check_eq("hb_fc", obs_fc, 1);

        // MUL/DIV with a 2-cycle memory stall in the middle
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("md_issue");
        check_eq("md_issue_pc", int'(obs_ctrl[7]), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("md_busy1");
        check_eq("md_busy1_ctrl", int'(obs_ctrl), 8'h19);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("md_ms1");
        check_eq("md_ms1_ctrl", int'(obs_ctrl), 8'h00);
        step("md_ms2");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("md_busy2");
        step("md_busy3");
        check_eq("md_busy3_ctrl", int'(obs_ctrl), 8'h19);
        step("md_done");
        check_eq("md_done_ctrl", int'(obs_ctrl), 8'hF8);
        check_eq("md_sc", obs_sc, 5);

        // Reset in the middle of a load stall
        do_reset();
        set_in(1, 1, 4, 0, 4, 0, 1, 0, 0, 0);
        step("rs_hit");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rs_assert");
        check_eq("rs_assert_ctrl", int'(obs_ctrl), 8'h07);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rs_release");
        check_eq("rs_release_ctrl", int'(obs_ctrl), 8'hF8);
        check_eq("rs_release_sc", obs_sc, 0);
        check_eq("rs_release_fc", obs_fc, 0);

        // Stall counter saturation
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step("sat");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_end");
        check_eq("sat_sc", obs_sc, MAXC);

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(99) >= 3),
                   ($urandom_range(99) < 50),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3),
                   ($urandom_range(99) < 70), ($urandom_range(99) < 50),
                   ($urandom_range(99) < 15), ($urandom_range(99) < 25),
                   ($urandom_range(99) < 20));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
